// File: rtl/hex_word_print_seq.sv
// Word-to-ASCII print sequencer: emits a word MSB-first as hex digit pairs (or raw bytes), then SEP_CHAR.
// Optional feature macro: HEX_PREFIX_EN adds a "0x" prefix before hex-mode words.
module hex_word_print_seq #(
    parameter int         WORD_BYTES = 4,
    parameter logic [7:0] SEP_CHAR   = 8'h20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [8*WORD_BYTES-1:0] req_word,
    input  logic                    req_raw,
    output logic                    ch_valid,
    input  logic                    ch_ready,
    output logic [7:0]              ch_data,
    output logic                    busy
);

    localparam int         WW       = 8 * WORD_BYTES;
    localparam logic [2:0] LAST_IDX = 3'(WORD_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
`ifdef HEX_PREFIX_EN
        S_PFX0 = 3'd1,
        S_PFX1 = 3'd2,
`endif
        S_HI   = 3'd3,
        S_LO   = 3'd4,
        S_SEP  = 3'd5
    } state_t;

    state_t          state_q, state_d;
    logic [WW-1:0]   word_q,  word_d;
    logic            raw_q,   raw_d;
    logic [2:0]      idx_q,   idx_d;
    logic            step;
    logic            busy_d;

    function automatic logic [7:0] hex_digit(input logic [3:0] n);
        return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
    endfunction

    // Character presented while sitting in state s; b is the current (top) byte of the word.
    function automatic logic [7:0] char_of(input state_t s, input logic [7:0] b, input logic raw);
        logic [7:0] c;
        c = 8'h00;
        case (s)
`ifdef HEX_PREFIX_EN
            S_PFX0:  c = 8'h30;
            S_PFX1:  c = 8'h78;
`endif
            S_HI:    c = raw ? b : hex_digit(b[7:4]);
            S_LO:    c = hex_digit(b[3:0]);
            S_SEP:   c = SEP_CHAR;
            default: c = 8'h00;
        endcase
        return c;
    endfunction

    assign step = ch_valid && ch_ready;

    always_comb begin
        // NOTE: every variable gets a default before the case so no path leaves it unassigned (no latch).
        state_d = state_q;
        word_d  = word_q;
        raw_d   = raw_q;
        idx_d   = idx_q;

        case (state_q)
            S_IDLE: begin
                idx_d = 3'd0;
                if (req_valid && req_ready) begin
                    word_d = req_word;
                    raw_d  = req_raw;
`ifdef HEX_PREFIX_EN
                    state_d = req_raw ? S_HI : S_PFX0;
`else
                    state_d = S_HI;
`endif
                end
            end
`ifdef HEX_PREFIX_EN
            S_PFX0: if (step) state_d = S_PFX1;
            S_PFX1: if (step) state_d = S_HI;
`endif
            S_HI: begin
                if (step) begin
                    if (!raw_q) begin
                        state_d = S_LO;
                    end else if (idx_q < LAST_IDX) begin
                        idx_d  = idx_q + 3'd1;
                        word_d = word_q << 8;
                    end else begin
                        state_d = S_SEP;
                    end
                end
            end
            S_LO: begin
                if (step) begin
                    if (idx_q < LAST_IDX) begin
                        idx_d   = idx_q + 3'd1;
                        word_d  = word_q << 8;
                        state_d = S_HI;
                    end else begin
                        state_d = S_SEP;
                    end
                end
            end
            S_SEP:   if (step) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase

        busy_d = (state_d != S_IDLE);
    end

    // Outputs are registered from the next-state view, so data is stable while the sink stalls.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q   <= S_IDLE;
            word_q    <= '0;
            raw_q     <= 1'b0;
            idx_q     <= 3'd0;
            req_ready <= 1'b0;
            ch_valid  <= 1'b0;
            ch_data   <= 8'h00;
            busy      <= 1'b0;
        end else begin
            state_q   <= state_d;
            word_q    <= word_d;
            raw_q     <= raw_d;
            idx_q     <= idx_d;
            req_ready <= !busy_d;
            ch_valid  <= busy_d;
            ch_data   <= char_of(state_d, word_d[WW-1 -: 8], raw_d);
            busy      <= busy_d;
        end
    end

endmodule

// File: tb/tb_hex_word_print_seq.sv
// Directed bench for hex_word_print_seq (WORD_BYTES=4); expectations adapt when HEX_PREFIX_EN is defined.
module tb_hex_word_print_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic [31:0] req_word;
    logic        req_raw;
    logic        ch_valid;
    logic        ch_ready;
    logic [7:0]  ch_data;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    logic [7:0] got[$];
    int         got_cyc[$];
    logic [7:0] exp_q[$];
    int         exit_cyc;
    bit         to_err;
    int         stall_err;
    int         rdy_err;

    hex_word_print_seq #(.WORD_BYTES(4), .SEP_CHAR(8'h20)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_word  (req_word),
        .req_raw   (req_raw),
        .ch_valid  (ch_valid),
        .ch_ready  (ch_ready),
        .ch_data   (ch_data),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic add_prefix();
`ifdef HEX_PREFIX_EN
        exp_q.push_front(8'h78);
        exp_q.push_front(8'h30);
`endif
    endtask

    // Starts at the negedge after accept; collects handshaken chars until busy falls.
    task automatic drain(input bit toggle, input int max_chars);
        int         c;
        bit         stalled;
        logic [7:0] held;
        c = 0; stalled = 0; held = 8'h00;
        got.delete(); got_cyc.delete();
        to_err = 0; stall_err = 0; rdy_err = 0;
        while (1) begin
            if (c > 200) begin to_err = 1; break; end
            if (!busy) break;
            if (req_ready) rdy_err++;
            if (stalled && (!ch_valid || ch_data !== held)) stall_err++;
            ch_ready = toggle ? (c % 2 == 0) : 1'b1;
            if (ch_valid && ch_ready) begin
                got.push_back(ch_data);
                got_cyc.push_back(c);
                stalled = 0;
                if (got.size() == max_chars) return;
            end else if (ch_valid) begin
                stalled = 1;
                held    = ch_data;
            end
            @(negedge clk);
            c++;
        end
        exit_cyc = c;
    endtask

    task automatic run_word(input logic [31:0] w, input logic raw, input bit toggle, input int max_chars);
        int k;
        k = 0;
        while (!req_ready && k < 20) begin @(negedge clk); k++; end
        req_valid = 1'b1; req_word = w; req_raw = raw;
        @(negedge clk);
        req_valid = 1'b0;
        drain(toggle, max_chars);
    endtask

    task automatic test_reset();
        rst = 1'b1; req_valid = 1'b0; req_word = '0; req_raw = 1'b0; ch_ready = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (req_ready !== 1'b0) $display("FAIL reset_req_ready: got %b want 0", req_ready); else n_pass++;
        n_checks++; if (ch_valid !== 1'b0) $display("FAIL reset_ch_valid: got %b want 0", ch_valid); else n_pass++;
        n_checks++; if (ch_data !== 8'h00) $display("FAIL reset_ch_data: got %h want 00", ch_data); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (req_ready !== 1'b1) $display("FAIL release_req_ready: got %b want 1", req_ready); else n_pass++;
    endtask

    task automatic test_hex_word();
        logic [7:0] g;
        exp_q = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h41, 8'h42, 8'h43, 8'h44, 8'h20};
        add_prefix();
        run_word(32'h1234ABCD, 1'b0, 1'b0, 100);
        n_checks++; if (to_err) $display("FAIL hex_timeout: got timeout want done"); else n_pass++;
        n_checks++; if (got.size() != exp_q.size()) $display("FAIL hex_count: got %0d want %0d", got.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            n_checks++; if (g !== exp_q[i]) $display("FAIL hex_char[%0d]: got %h want %h", i, g, exp_q[i]); else n_pass++;
            n_checks++; if (i < got_cyc.size() && got_cyc[i] != i) $display("FAIL hex_cycle[%0d]: got %0d want %0d", i, got_cyc[i], i); else n_pass++;
        end
        n_checks++; if (exit_cyc != exp_q.size()) $display("FAIL hex_idle_cycle: got %0d want %0d", exit_cyc, exp_q.size()); else n_pass++;
        n_checks++; if (req_ready !== 1'b1) $display("FAIL hex_ready_after_sep: got %b want 1", req_ready); else n_pass++;
        n_checks++; if (ch_valid !== 1'b0) $display("FAIL hex_valid_after_sep: got %b want 0", ch_valid); else n_pass++;
    endtask

    task automatic test_backpressure();
        logic [7:0] g;
        exp_q = '{8'h30, 8'h30, 8'h46, 8'h46, 8'h30, 8'h41, 8'h35, 8'h43, 8'h20};
        add_prefix();
        run_word(32'h00FF0A5C, 1'b0, 1'b1, 100);
        n_checks++; if (to_err) $display("FAIL bp_timeout: got timeout want done"); else n_pass++;
        n_checks++; if (got.size() != exp_q.size()) $display("FAIL bp_count: got %0d want %0d", got.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            n_checks++; if (g !== exp_q[i]) $display("FAIL bp_char[%0d]: got %h want %h", i, g, exp_q[i]); else n_pass++;
        end
        n_checks++; if (stall_err != 0) $display("FAIL bp_stall_stable: got %0d unstable stalls want 0", stall_err); else n_pass++;
    endtask

    task automatic test_raw();
        logic [7:0] g;
        exp_q = '{8'h48, 8'h69, 8'h21, 8'h21, 8'h20};
        run_word(32'h48692121, 1'b1, 1'b0, 100);
        n_checks++; if (got.size() != 5) $display("FAIL raw_count: got %0d want 5", got.size()); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            n_checks++; if (g !== exp_q[i]) $display("FAIL raw_char[%0d]: got %h want %h", i, g, exp_q[i]); else n_pass++;
        end
        n_checks++; if (exit_cyc != 5) $display("FAIL raw_idle_cycle: got %0d want 5", exit_cyc); else n_pass++;
    endtask

    task automatic test_req_while_busy();
        logic [7:0] g;
        int         k;
        k = 0;
        while (!req_ready && k < 20) begin @(negedge clk); k++; end
        req_valid = 1'b1; req_word = 32'hA5A5A5A5; req_raw = 1'b0;
        @(negedge clk);
        req_word = 32'h11223344; req_raw = 1'b1;   // held request, must wait for IDLE
        drain(1'b0, 100);
        exp_q = '{8'h41, 8'h35, 8'h41, 8'h35, 8'h41, 8'h35, 8'h41, 8'h35, 8'h20};
        add_prefix();
        n_checks++; if (rdy_err != 0) $display("FAIL busy_req_ready: got %0d cycles high want 0", rdy_err); else n_pass++;
        n_checks++; if (got.size() != exp_q.size()) $display("FAIL busy_w1_count: got %0d want %0d", got.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            n_checks++; if (g !== exp_q[i]) $display("FAIL busy_w1_char[%0d]: got %h want %h", i, g, exp_q[i]); else n_pass++;
        end
        n_checks++; if (req_ready !== 1'b1) $display("FAIL busy_idle_ready: got %b want 1", req_ready); else n_pass++;
        @(negedge clk);
        req_valid = 1'b0;
        n_checks++; if (ch_valid !== 1'b1 || busy !== 1'b1) $display("FAIL busy_w2_start: got valid %b busy %b want 1 1", ch_valid, busy); else n_pass++;
        drain(1'b0, 100);
        exp_q = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h20};
        n_checks++; if (got.size() != 5) $display("FAIL busy_w2_count: got %0d want 5", got.size()); else n_pass++;
        for (int i = 0; i < 5; i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            n_checks++; if (g !== exp_q[i]) $display("FAIL busy_w2_char[%0d]: got %h want %h", i, g, exp_q[i]); else n_pass++;
        end
    endtask

    task automatic test_reset_mid_word();
        logic [7:0] g;
        run_word(32'hDEADBEEF, 1'b0, 1'b0, 3);
        n_checks++; if (got.size() != 3) $display("FAIL abort_pre_count: got %0d want 3", got.size()); else n_pass++;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        n_checks++; if (ch_valid !== 1'b0) $display("FAIL abort_ch_valid: got %b want 0", ch_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL abort_busy: got %b want 0", busy); else n_pass++;
        n_checks++; if (req_ready !== 1'b0) $display("FAIL abort_req_ready: got %b want 0", req_ready); else n_pass++;
        rst = 1'b0;
        @(negedge clk);
        n_checks++; if (busy !== 1'b0 || ch_valid !== 1'b0) $display("FAIL abort_no_resume: got busy %b valid %b want 0 0", busy, ch_valid); else n_pass++;
        exp_q = '{8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h30, 8'h31, 8'h20};
        add_prefix();
        run_word(32'h00000001, 1'b0, 1'b0, 100);
        n_checks++; if (got.size() != exp_q.size()) $display("FAIL abort_next_count: got %0d want %0d", got.size(), exp_q.size()); else n_pass++;
        for (int i = 0; i < exp_q.size(); i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            n_checks++; if (g !== exp_q[i]) $display("FAIL abort_next_char[%0d]: got %h want %h", i, g, exp_q[i]); else n_pass++;
        end
    endtask

`ifdef HEX_PREFIX_EN
    task automatic test_prefix();
        logic [7:0] g;
        exp_q = '{8'h30, 8'h78, 8'h30, 8'h30, 8'h30, 8'h30, 8'h43, 8'h41, 8'h46, 8'h45, 8'h20};
        run_word(32'h0000CAFE, 1'b0, 1'b0, 100);
        n_checks++; if (got.size() != 11) $display("FAIL pfx_count: got %0d want 11", got.size()); else n_pass++;
        for (int i = 0; i < 11; i++) begin
            g = (i < got.size()) ? got[i] : 8'hxx;
            n_checks++; if (g !== exp_q[i]) $display("FAIL pfx_char[%0d]: got %h want %h", i, g, exp_q[i]); else n_pass++;
        end
    endtask
`endif

    initial begin
        test_reset();
        test_hex_word();
        test_backpressure();
        test_raw();
        test_req_while_busy();
        test_reset_mid_word();
`ifdef HEX_PREFIX_EN
        test_prefix();
`endif
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
